// File: rtl/ffre_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ffre_bank_ctrl_if
//  Brief    : Request/grant/bank bus between requesters and ffre_bank_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
interface ffre_bank_ctrl_if #(
    parameter int NREQ = 4,
    parameter int NREG = 21,
    parameter int DW   = 8,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic               sweep_req;
    logic               sweep_busy;
    logic [NREG-1:0]    ena;
    logic [NREG*DW-1:0] q;
    logic               err;

    // Requester side
    modport master (
        output req, wr_addr, wr_data, sweep_req,
        input  gnt, sweep_busy, ena, q, err
    );

    // Bank controller side
    modport slave (
        input  req, wr_addr, wr_data, sweep_req,
        output gnt, sweep_busy, ena, q, err
    );
endinterface
`default_nettype wire

// File: rtl/ffre_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ffre_bank_ctrl
//  Brief    : Round-robin write scheduler and one-entry-per-cycle clear sweep
//             for a bank of enable-gated registers
//  Revision : 1.0 - initial release
// ============================================================================
module ffre_bank_ctrl #(
    parameter int NREQ = 4,
    parameter int NREG = 21,
    parameter int DW   = 8,
    parameter int AW   = 5
) (
    input  wire logic         clk,
    input  wire logic         clr,
    ffre_bank_ctrl_if.slave   bus
);

    localparam int            c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] c_LAST = AW'(NREG - 1);
    localparam logic [AW:0]   c_NREG = (AW+1)'(NREG);
    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_idx;
    logic [c_PW-1:0]    r_ptr;
    logic [DW-1:0]      r_mem [NREG];
    logic [NREQ-1:0]    r_gnt;
    logic [NREG-1:0]    r_ena;
    logic               r_err;

    logic               w_any;
    logic [c_PW-1:0]    w_win;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic               w_inrange;
    logic               w_do_grant;
    logic               w_do_clear;
    logic               w_start;

    // Round-robin search: first asserted req strictly after the last winner
    always_comb begin
        int w_j;
        w_any = 1'b0;
        w_win = '0;
        w_j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = (int'(r_ptr) + k) % NREQ;
            if (!w_any && bus.req[w_j]) begin
                w_any = 1'b1;
                w_win = c_PW'(w_j);
            end
        end
    end

    assign w_addr     = bus.wr_addr[w_win*AW +: AW];
    assign w_data     = bus.wr_data[w_win*DW +: DW];
    assign w_inrange  = ({1'b0, w_addr} < c_NREG);
    assign w_start    = (r_state == IDLE) && bus.sweep_req;
    assign w_do_grant = (r_state == IDLE) && !bus.sweep_req && w_any;
    assign w_do_clear = (r_state == SWEEP);

    // State register; clr aborts any sweep in progress
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: sweep wins over requests, leaves after the last entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.sweep_req)  w_state_nxt = SWEEP;
            SWEEP:   if (r_idx == c_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bank storage, strobes, grant pulse, rr pointer, sticky error
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
            r_gnt <= '0;
            r_ena <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
            r_ptr <= c_PTR_RST;
        end else begin
            r_gnt <= '0;
            r_ena <= '0;
            if (w_do_clear) begin
                r_mem[r_idx] <= '0;
                r_ena[r_idx] <= 1'b1;
                r_idx        <= (r_idx == c_LAST) ? '0 : r_idx + AW'(1);
            end else if (w_start) begin
                r_idx <= '0;
            end else if (w_do_grant) begin
                r_gnt[w_win] <= 1'b1;
                r_ptr        <= w_win;
                if (w_inrange) begin
                    r_mem[w_addr] <= w_data;
                    r_ena[w_addr] <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.ena        = r_ena;
    assign bus.err        = r_err;
    assign bus.sweep_busy = (r_state == SWEEP);

    for (genvar k = 0; k < NREG; k++) begin : g_q
        assign bus.q[k*DW +: DW] = r_mem[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_ffre_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ffre_bank_ctrl
//  Brief    : Directed + randomized bench for ffre_bank_ctrl against a
//             cycle-level behavioural model of the bank
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ffre_bank_ctrl;

    localparam int NREQ = 4;
    localparam int NREG = 21;
    localparam int DW   = 8;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic clr = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [DW-1:0]   m_q [NREG];
    int              m_ptr;
    int              m_left;
    int              m_next;
    logic            m_err;
    logic [NREQ-1:0] m_gnt;
    logic [NREG-1:0] m_ena;

    ffre_bank_ctrl_if #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) bus ();

    ffre_bank_ctrl #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG*DW-1:0] model_flat();
        logic [NREG*DW-1:0] v;
        for (int k = 0; k < NREG; k++) v[k*DW +: DW] = m_q[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_q[k] = '0;
        m_ptr  = NREQ - 1;
        m_left = 0;
        m_next = 0;
        m_err  = 1'b0;
        m_gnt  = '0;
        m_ena  = '0;
    endtask

    // One clock edge of the bank as described by its rules
    task automatic model_step();
        int w;
        int a;
        bit found;
        m_gnt = '0;
        m_ena = '0;
        if (m_left > 0) begin
            m_q[m_next]   = '0;
            m_ena[m_next] = 1'b1;
            m_next++;
            m_left--;
        end else if (bus.sweep_req) begin
            m_left = NREG;
            m_next = 0;
        end else if (bus.req != '0) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && bus.req[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    w = (m_ptr + k) % NREQ;
                end
            end
            a = int'(bus.wr_addr[w*AW +: AW]);
            m_gnt[w] = 1'b1;
            m_ptr    = w;
            if (a < NREG) begin
                m_q[a]   = bus.wr_data[w*DW +: DW];
                m_ena[a] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt",  256'(bus.gnt), 256'(m_gnt));
        chk("ena",  256'(bus.ena), 256'(m_ena));
        chk("busy", 256'(bus.sweep_busy), 256'(m_left > 0));
        chk("err",  256'(bus.err), 256'(m_err));
        chk("q",    256'(bus.q), 256'(model_flat()));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        clr = 1'b0;
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        bus.wr_addr[i*AW +: AW] = AW'(addr);
        bus.wr_data[i*DW +: DW] = DW'(data);
    endtask

    initial begin
        logic [NREG*DW-1:0] saved_q;
        bus.req       = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.sweep_req = 1'b0;

        // Reset with sweep and all requests pending
        bus.sweep_req = 1'b1;
        bus.req       = 4'b1111;
        do_reset();
        chk("rst_busy", 256'(bus.sweep_busy), 256'(0));
        tick();
        chk("rst_sweep_entry", 256'(bus.sweep_busy), 256'(1));
        chk("rst_no_gnt", 256'(bus.gnt), 256'(0));
        bus.sweep_req = 1'b0;
        bus.req       = '0;
        repeat (NREG) tick();

        // Round-robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i, 8'hA0 + i);
        bus.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rr_gnt", 256'(bus.gnt), 256'(4'b0001 << (c % 4)));
        end
        bus.req = '0;
        for (int i = 0; i < NREQ; i++)
            chk("rr_q", 256'(bus.q[i*DW +: DW]), 256'(8'hA0 + i));

        // Priority skip from pointer 1
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b1001;
        tick();
        chk("skip_first", 256'(bus.gnt), 256'(4'b1000));
        tick();
        chk("skip_second", 256'(bus.gnt), 256'(4'b0001));
        bus.req = '0;

        // Out-of-range write
        saved_q = bus.q;
        set_req(2, 25, 8'hFF);
        bus.req = 4'b0100;
        tick();
        chk("oor_gnt", 256'(bus.gnt), 256'(4'b0100));
        chk("oor_ena", 256'(bus.ena), 256'(0));
        chk("oor_err", 256'(bus.err), 256'(1));
        chk("oor_q",   256'(bus.q), 256'(saved_q));
        bus.req = '0;
        repeat (3) tick();
        chk("oor_sticky", 256'(bus.err), 256'(1));
        do_reset();
        chk("oor_clr", 256'(bus.err), 256'(0));

        // Sweep colliding with a request on the same edge
        bus.req = 4'b0001;
        for (int k = 0; k < NREG; k++) begin
            set_req(0, k, 8'h11 + k);
            tick();
        end
        bus.sweep_req = 1'b1;
        set_req(0, 3, 8'h55);
        tick();
        chk("col_no_gnt", 256'(bus.gnt), 256'(0));
        chk("col_busy",   256'(bus.sweep_busy), 256'(1));
        bus.sweep_req = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            tick();
            chk("col_ena_walk", 256'(bus.ena), 256'(21'd1 << k));
            chk("col_busy_win", 256'(bus.sweep_busy), 256'(k != NREG - 1));
        end
        chk("col_q_zero", 256'(bus.q), 256'(0));
        tick();
        chk("col_late_gnt", 256'(bus.gnt), 256'(4'b0001));
        bus.req = '0;

        // Abort mid-sweep at index 10, then restart
        do_reset();
        bus.sweep_req = 1'b1;
        tick();
        bus.sweep_req = 1'b0;
        repeat (10) tick();
        chk("abort_pre_busy", 256'(bus.sweep_busy), 256'(1));
        do_reset();
        chk("abort_busy", 256'(bus.sweep_busy), 256'(0));
        bus.sweep_req = 1'b1;
        tick();
        bus.sweep_req = 1'b0;
        tick();
        chk("abort_restart", 256'(bus.ena), 256'(1));
        repeat (NREG - 1) tick();

        // Randomized traffic with occasional sweeps and resets
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 99) == 0) set_req(i, $urandom_range(NREG, 31), $urandom);
                else                            set_req(i, $urandom_range(0, NREG - 1), $urandom);
            end
            bus.sweep_req = ($urandom_range(0, 39) == 0);
            tick();
            if (c % 300 == 299) do_reset();
        end
        bus.req       = '0;
        bus.sweep_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
